// File: rtl/mips32_dmem_responder.sv
// Memory end of a MIPS32 load/store port: word-addressed RAM behind a valid/ready
// request channel and a stallable response channel, with a fixed number of wait states.
module mips32_dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2     // legal range 1..15
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  // Handshakes: a request transfers on an edge with req_valid && req_ready; a response
  // transfers on an edge with resp_valid && resp_ready. Response fields hold until then.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit DIRECT = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;

  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                enter_resp;
  logic                mem_we;
  logic                txn_we;
  logic [ADDR_W-1:0]   txn_addr;
  logic [31:0]         txn_wdata;
  logic                in_range;
  logic [IDX_W-1:0]    idx;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign busy       = (state_q != IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // With one cycle of latency the RAM access happens on the acceptance edge itself,
  // so the transaction comes straight from the request inputs rather than the latch.
  assign txn_we    = DIRECT ? req_we    : we_q;
  assign txn_addr  = DIRECT ? req_addr  : addr_q;
  assign txn_wdata = DIRECT ? req_wdata : wdata_q;
  assign in_range  = (txn_addr < ADDR_W'(DEPTH));
  assign idx       = txn_addr[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    valid_d    = valid_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (DIRECT) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      valid_d = 1'b1;
      err_d   = !in_range;
      rdata_d = (in_range && !txn_we) ? mem[idx] : 32'd0;
    end
    // Reset on the commit edge drops the store.
    mem_we = enter_resp && in_range && txn_we && !rst;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk1) begin
    if (mem_we) mem[idx] <= txn_wdata;
  end

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Directed bench for mips32_dmem_responder: a LATENCY=2 instance for the functional
// scenarios plus LATENCY=1 and LATENCY=15 instances for request pacing.
module tb_mips32_dmem_responder;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_we, b_resp_ready;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        l1_req_ready, l1_resp_valid, l1_resp_err, l1_busy;
  logic [31:0] l1_resp_rdata;
  logic        l15_req_ready, l15_resp_valid, l15_resp_err, l15_busy;
  logic [31:0] l15_resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int          lat;
  logic [31:0] rd;
  logic        er;

  mips32_dmem_responder #(.DEPTH(1024), .ADDR_W(32), .LATENCY(2)) dut (
    .clk1(clk1), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  mips32_dmem_responder #(.DEPTH(1024), .ADDR_W(32), .LATENCY(1)) u_l1 (
    .clk1(clk1), .rst(rst), .req_valid(b_req_valid), .req_ready(l1_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(l1_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(l1_resp_rdata),
    .resp_err(l1_resp_err), .busy(l1_busy)
  );

  mips32_dmem_responder #(.DEPTH(1024), .ADDR_W(32), .LATENCY(15)) u_l15 (
    .clk1(clk1), .rst(rst), .req_valid(b_req_valid), .req_ready(l15_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(l15_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(l15_resp_rdata),
    .resp_err(l15_resp_err), .busy(l15_busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  // ---------------- driver tasks ----------------
  // Issues one request, holds it until accepted, scrambles the inputs afterwards and
  // returns the number of edges from acceptance to the first edge seeing resp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int l, output logic [31:0] rdata, output logic err);
    int guard;
    @(negedge clk1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 64) begin
      @(negedge clk1);
      guard++;
    end
    @(negedge clk1);
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
    l = 1;
    while (!resp_valid && l < 64) begin
      @(negedge clk1);
      l++;
    end
    if (!resp_valid) l = -1;
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk1);
    resp_ready = 1'b0;
  endtask

  // Holds a store to addr 7 until accepted, leaving the bench at the negedge after acceptance.
  task automatic start_store7();
    int guard;
    @(negedge clk1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'hA5A5A5A5;
    guard = 0;
    while (!req_ready && guard < 64) begin
      @(negedge clk1);
      guard++;
    end
    @(negedge clk1);
    req_valid = 1'b0; req_wdata = 32'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk1);
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %0b want 0", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else n_pass++;
    n_checks++; if (resp_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", resp_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    rst = 1'b0;
    @(negedge clk1);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %0b want 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (l1_req_ready !== 1'b1 || l15_req_ready !== 1'b1)
      $display("FAIL idle_req_ready_l1_l15: got %0b%0b want 11", l1_req_ready, l15_req_ready); else n_pass++;
  endtask

  task automatic test_store_load();
    do_req(1'b1, 32'd5, 32'hDEADBEEF, lat, rd, er);
    n_checks++; if (lat !== 2) $display("FAIL store_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'd0) $display("FAIL store_rdata: got %h want 0", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL store_err: got %0b want 0", er); else n_pass++;
    ack();
    do_req(1'b0, 32'd5, 32'h0, lat, rd, er);
    n_checks++; if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL load_err: got %0b want 0", er); else n_pass++;
    ack();
  endtask

  task automatic test_backpressure();
    do_req(1'b0, 32'd5, 32'h0, lat, rd, er);
    n_checks++; if (lat !== 2 || rd !== 32'hDEADBEEF) $display("FAIL bp_first: got lat %0d rdata %h want 2 deadbeef", lat, rd); else n_pass++;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'hFFFF0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got v%0b d%h e%0b rdy%0b want v1 ddeadbeef e0 rdy0", i, resp_valid, resp_rdata, resp_err, req_ready);
      else n_pass++;
    end
    ack();
    n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_handshake_edge: got busy%0b v%0b rdy%0b want busy0 v0 rdy1", busy, resp_valid, req_ready); else n_pass++;
    req_valid = 1'b0;
    do_req(1'b0, 32'd5, 32'h0, lat, rd, er);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL bp_ram_unchanged: got %h want deadbeef", rd); else n_pass++;
    ack();
  endtask

  task automatic test_out_of_range();
    do_req(1'b1, 32'd0, 32'h0BADF00D, lat, rd, er); ack();
    do_req(1'b1, 32'd1023, 32'h3FF3FF00, lat, rd, er); ack();
    do_req(1'b1, 32'd1024, 32'h12345678, lat, rd, er);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) $display("FAIL oor_store: got e%0b d%h lat%0d want e1 d0 lat2", er, rd, lat); else n_pass++;
    ack();
    do_req(1'b0, 32'd0, 32'h0, lat, rd, er);
    n_checks++; if (er !== 1'b0 || rd !== 32'h0BADF00D) $display("FAIL oor_no_alias: got e%0b d%h want e0 d0badf00d", er, rd); else n_pass++;
    ack();
    do_req(1'b0, 32'd1023, 32'h0, lat, rd, er);
    n_checks++; if (er !== 1'b0 || rd !== 32'h3FF3FF00) $display("FAIL top_word: got e%0b d%h want e0 d3ff3ff00", er, rd); else n_pass++;
    ack();
    do_req(1'b0, 32'hFFFFFFFF, 32'h0, lat, rd, er);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL oor_load_max: got e%0b d%h want e1 d0", er, rd); else n_pass++;
    ack();
  endtask

  task automatic test_reset_mid_op();
    do_req(1'b1, 32'd7, 32'h11112222, lat, rd, er); ack();
    start_store7();
    n_checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) $display("FAIL mid_wait_state: got busy%0b v%0b want busy1 v0", busy, resp_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) $display("FAIL rst_in_wait: got busy%0b v%0b want busy0 v0", busy, resp_valid); else n_pass++;
    do_req(1'b0, 32'd7, 32'h0, lat, rd, er);
    n_checks++; if (rd !== 32'h11112222) $display("FAIL rst_wait_dropped: got %h want 11112222", rd); else n_pass++;
    ack();
    start_store7();
    @(negedge clk1);
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL mid_resp_state: got v%0b want v1", resp_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0)
      $display("FAIL rst_in_resp: got busy%0b v%0b d%h want busy0 v0 d0", busy, resp_valid, resp_rdata); else n_pass++;
    do_req(1'b0, 32'd7, 32'h0, lat, rd, er);
    n_checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL rst_resp_committed: got %h want a5a5a5a5", rd); else n_pass++;
    ack();
  endtask

  task automatic test_back_to_back();
    int a1[$];
    int a15[$];
    logic v1 [80];
    logic v15 [80];
    @(negedge clk1);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'd3; b_resp_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (l1_req_ready) a1.push_back(c);
      if (l15_req_ready) a15.push_back(c);
      v1[c]  = l1_resp_valid;
      v15[c] = l15_resp_valid;
      @(negedge clk1);
    end
    b_req_valid = 1'b0;
    n_checks++; if (a1.size() < 3 || a1[1] - a1[0] != 2 || a1[2] - a1[1] != 2)
      $display("FAIL l1_spacing: got n%0d gaps %0d %0d want 2 2", a1.size(), a1[1] - a1[0], a1[2] - a1[1]); else n_pass++;
    n_checks++; if (a15.size() < 3 || a15[1] - a15[0] != 16 || a15[2] - a15[1] != 16)
      $display("FAIL l15_spacing: got n%0d gaps %0d %0d want 16 16", a15.size(), a15[1] - a15[0], a15[2] - a15[1]); else n_pass++;
    n_checks++; if (a1.size() < 1 || v1[a1[0] + 1] !== 1'b1)
      $display("FAIL l1_latency: got v%0b want 1", (a1.size() < 1) ? 1'b0 : v1[a1[0] + 1]); else n_pass++;
    n_checks++; if (a15.size() < 1 || v15[a15[0] + 14] !== 1'b0 || v15[a15[0] + 15] !== 1'b1)
      $display("FAIL l15_latency: got v@14=%0b v@15=%0b want 0 1",
               (a15.size() < 1) ? 1'b0 : v15[a15[0] + 14], (a15.size() < 1) ? 1'b0 : v15[a15[0] + 15]); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0; b_resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips32_dmem_responder.md
Name: mips32_dmem_responder

Overview:
- Data-memory responder: the memory end of a valid/ready load/store interface that a MIPS32 pipeline core initiates.
- Holds a word-addressed 32-bit RAM and serves one request at a time with programmable wait states.
- Returns read data or a write acknowledgement over a separate response channel that can be stalled.
- Flags out-of-range word addresses instead of aliasing them.

Parameters:
DEPTH, 1024, number of 32-bit words; valid word addresses are 0..DEPTH-1
ADDR_W, 32, request address width; the address is a word address, matching the core's ALU output
LATENCY, 2, cycles from request acceptance to resp_valid rising; legal range 1..15

Ports:
clk1  input  1  single clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store (SW), 0 = load (LW)
req_addr  input  ADDR_W  word address
req_wdata  input  32  store data
resp_valid  output  1  response present
resp_ready  input  1  core accepts the response this cycle
resp_rdata  output  32  load data; 0 for stores and for errors
resp_err  output  1  address was >= DEPTH
busy  output  1  high whenever the block is not in IDLE

Behaviour:
- The clock is clk1 and the reset is synchronous, active-high rst; single clock domain.
- FSM states: IDLE, WAIT, RESP.
- Reset (rst=1 at an edge):
  - state goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - RAM contents are NOT cleared.
  - req_ready is forced to 0 while rst is high.
- IDLE:
  - req_ready=1 (combinational from state and rst).
  - Acceptance: an edge where req_valid and req_ready are both 1.
  - On acceptance, latch req_we, req_addr and req_wdata. Inputs may change afterwards.
  - If LATENCY=1, go directly to RESP. Otherwise go to WAIT with the counter loaded to LATENCY-2.
- WAIT:
  - req_ready=0.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, go to RESP.
- Entry into RESP (the single edge where resp_valid rises):
  - In-range store: RAM[addr] <= wdata; resp_rdata=0; resp_err=0.
  - In-range load: resp_rdata = RAM[addr] as it stands at that edge; resp_err=0.
  - Out-of-range (addr >= DEPTH, full ADDR_W compare, no truncation): no RAM write; resp_rdata=0; resp_err=1.
  - Net effect: with acceptance at edge t, resp_valid is high from edge t+LATENCY.
- RESP:
  - req_ready=0.
  - resp_valid, resp_rdata and resp_err stay stable until an edge where resp_ready=1.
  - On that edge go to IDLE and clear resp_valid, resp_rdata and resp_err to 0.
  - No new request is accepted on the response-handshake edge.
  - Minimum spacing between acceptances is LATENCY+1 cycles.
- resp_ready is ignored outside RESP.
- Ordering: requests are strictly serialized, so a load issued after a store to the same address returns the stored value.
- Reset mid-operation:
  - From WAIT, the pending transaction is dropped and no write occurs.
  - From RESP, the write has already been committed and persists; the response is discarded.
- req_valid seen while not in IDLE is ignored, not queued. The requester must hold the request until it is accepted.
- busy = (state != IDLE).

Test Plan:
- Reset then idle: rst high 2 cycles -> resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=0 during reset and 1 after.
- Store then load (LATENCY=2): store addr 5, data 0xDEADBEEF accepted at edge t -> resp_valid at t+2 with rdata=0 and err=0. Load addr 5 -> rdata=0xDEADBEEF, err=0, exactly 2 cycles after acceptance.
- Response backpressure: hold resp_ready=0 for 4 cycles after a load of addr 5 -> resp_valid, rdata and err stay constant. req_valid is asserted meanwhile with req_ready=0, and the RAM is unchanged.
- Out-of-range: store addr 1024, data 0x12345678 -> err=1, rdata=0. A subsequent load of addr 0 returns its prior value (no aliasing). A load of addr 0xFFFFFFFF -> err=1.
- LATENCY=1 and LATENCY=15 builds: back-to-back loads with resp_ready tied to 1 -> acceptances spaced exactly 2 and 16 cycles apart.
- Reset mid-operation: store addr 7, data 0xA5A5A5A5, with rst pulsed during WAIT -> a later load of addr 7 returns the old value. The same store with rst during RESP -> a later load returns 0xA5A5A5A5.
